// File: rtl/ui_pkg.sv
// Shared types and constants for the front-panel UI controller.
// Holds the FSM/menu encodings, gain limits and the key-event priority picker.
package ui_pkg;

    localparam int NUM_BANDS = 6;
    localparam int GAIN_W    = 5;
    localparam logic signed [GAIN_W-1:0] GAIN_MAX = GAIN_W'(12);
    localparam logic signed [GAIN_W-1:0] GAIN_MIN = GAIN_W'(-12);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_TOP  = 3'd1,
        ST_MENU = 3'd2,
        ST_BAND = 3'd3,
        ST_GAIN = 3'd4
    } ui_state_e;

    typedef enum logic [2:0] {
        MENU_EQ     = 3'd0,
        MENU_OFFSET = 3'd1,
        MENU_RESET  = 3'd2
    } menu_state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_BACK,
        EV_ENTER,
        EV_UP,
        EV_DOWN
    } ui_event_e;

    // Only one key is acted on per cycle; the rest are dropped.
    function automatic ui_event_e pick_event(input logic back, input logic enter,
                                             input logic up, input logic down);
        if (back)  return EV_BACK;
        if (enter) return EV_ENTER;
        if (up)    return EV_UP;
        if (down)  return EV_DOWN;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/ui_controller_if.sv
// Key/init inputs and display/EQ outputs of the UI controller.
// master = the panel/codec side driving keys, slave = the controller itself.
interface ui_controller_if;
    import ui_pkg::*;

    logic                          i_key_up;
    logic                          i_key_down;
    logic                          i_key_enter;
    logic                          i_key_back;
    logic                          i_init_done;
    logic [2:0]                    o_state;
    logic [2:0]                    o_menu_state;
    logic [2:0]                    o_band;
    logic [31:0]                   o_gain;
    logic [NUM_BANDS*GAIN_W-1:0]   o_gains;
    logic [2:0]                    o_offset;
    logic                          o_play_enable;
    logic                          o_eq_reset;

    modport master (
        output i_key_up, i_key_down, i_key_enter, i_key_back, i_init_done,
        input  o_state, o_menu_state, o_band, o_gain, o_gains, o_offset,
               o_play_enable, o_eq_reset
    );

    modport slave (
        input  i_key_up, i_key_down, i_key_enter, i_key_back, i_init_done,
        output o_state, o_menu_state, o_band, o_gain, o_gains, o_offset,
               o_play_enable, o_eq_reset
    );
endinterface

// File: rtl/key_edge.sv
// Turns an active-low key level into a registered one-cycle press pulse.
// Latency: pulse appears one edge after the 1->0 transition; no backpressure.
// A key held through reset stays disarmed until it has been seen released.
module key_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic key_q;
    logic armed_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key_q   <= 1'b1;
            armed_q <= 1'b0;
            o_press <= 1'b0;
        end else begin
            key_q   <= i_key_n;
            armed_q <= armed_q | i_key_n;
            o_press <= armed_q & key_q & ~i_key_n;
        end
    end

endmodule

// File: rtl/ui_controller.sv
// Menu/EQ front-panel controller: keys navigate TOP/MENU/BAND/GAIN screens.
// Latency: one cycle from registered press pulse to registered outputs.
// No backpressure: one event acted on per cycle, lower-priority events dropped.
module ui_controller
    import ui_pkg::*;
(
    input logic            i_clk,
    input logic            i_rst_n,
    ui_controller_if.slave ui
);

    logic up_evt, down_evt, enter_evt, back_evt;

    key_edge u_key_up    (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_n(ui.i_key_up),    .o_press(up_evt));
    key_edge u_key_down  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_n(ui.i_key_down),  .o_press(down_evt));
    key_edge u_key_enter (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_n(ui.i_key_enter), .o_press(enter_evt));
    key_edge u_key_back  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_n(ui.i_key_back),  .o_press(back_evt));

    ui_state_e                        state_q, state_d;
    menu_state_e                      menu_q, menu_d;
    logic [2:0]                       band_q, band_d;
    logic [NUM_BANDS-1:0][GAIN_W-1:0] gains_q, gains_d;
    logic [2:0]                       offset_q, offset_d;
    logic                             play_q, play_d;
    logic                             eq_reset_q, eq_reset_d;
    logic [31:0]                      gain_q, gain_d;
    ui_event_e                        evt;
    logic [2:0]                       sel_q, sel_d;
    logic signed [GAIN_W-1:0]         g_cur;

    assign evt   = pick_event(back_evt, enter_evt, up_evt, down_evt);
    assign sel_q = band_q - 3'd1;
    assign g_cur = gains_q[sel_q];

    always_comb begin
        state_d    = state_q;
        menu_d     = menu_q;
        band_d     = band_q;
        gains_d    = gains_q;
        offset_d   = offset_q;
        play_d     = play_q;
        eq_reset_d = 1'b0;

        case (state_q)
            ST_INIT: if (ui.i_init_done) state_d = ST_TOP;
            ST_TOP: begin
                case (evt)
                    EV_BACK:  begin state_d = ST_MENU; menu_d = MENU_EQ; end
                    EV_ENTER: play_d = ~play_q;
                    default:  ;
                endcase
            end
            ST_MENU: begin
                case (evt)
                    EV_BACK: state_d = ST_TOP;
                    EV_ENTER: begin
                        case (menu_q)
                            MENU_EQ:     begin state_d = ST_BAND; band_d = 3'd1; end
                            MENU_OFFSET: offset_d = offset_q + 3'd1;
                            MENU_RESET:  begin gains_d = '0; offset_d = 3'd0; eq_reset_d = 1'b1; end
                            default:     ;
                        endcase
                    end
                    EV_UP: begin
                        case (menu_q)
                            MENU_EQ:     menu_d = MENU_OFFSET;
                            MENU_OFFSET: menu_d = MENU_RESET;
                            default:     menu_d = MENU_EQ;
                        endcase
                    end
                    EV_DOWN: begin
                        case (menu_q)
                            MENU_RESET:  menu_d = MENU_OFFSET;
                            MENU_OFFSET: menu_d = MENU_EQ;
                            default:     menu_d = MENU_RESET;
                        endcase
                    end
                    default: ;
                endcase
            end
            ST_BAND: begin
                case (evt)
                    EV_UP:    band_d = (band_q == 3'(NUM_BANDS)) ? 3'd1 : band_q + 3'd1;
                    EV_DOWN:  band_d = (band_q == 3'd1) ? 3'(NUM_BANDS) : band_q - 3'd1;
                    EV_ENTER: state_d = ST_GAIN;
                    EV_BACK:  state_d = ST_MENU;
                    default:  ;
                endcase
            end
            ST_GAIN: begin
                case (evt)
                    EV_UP:   if (g_cur < GAIN_MAX) gains_d[sel_q] = g_cur + GAIN_W'(1);
                    EV_DOWN: if (g_cur > GAIN_MIN) gains_d[sel_q] = g_cur - GAIN_W'(1);
                    EV_ENTER, EV_BACK: state_d = ST_BAND;
                    default: ;
                endcase
            end
            default: state_d = ST_INIT;
        endcase

        // o_gain is registered alongside gains so both always agree.
        sel_d  = band_d - 3'd1;
        gain_d = {{(32-GAIN_W){gains_d[sel_d][GAIN_W-1]}}, gains_d[sel_d]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_INIT;
            menu_q     <= MENU_EQ;
            band_q     <= 3'd1;
            gains_q    <= '0;
            offset_q   <= 3'd0;
            play_q     <= 1'b0;
            eq_reset_q <= 1'b0;
            gain_q     <= '0;
        end else begin
            state_q    <= state_d;
            menu_q     <= menu_d;
            band_q     <= band_d;
            gains_q    <= gains_d;
            offset_q   <= offset_d;
            play_q     <= play_d;
            eq_reset_q <= eq_reset_d;
            gain_q     <= gain_d;
        end
    end

    assign ui.o_state       = state_q;
    assign ui.o_menu_state  = menu_q;
    assign ui.o_band        = band_q;
    assign ui.o_gain        = gain_q;
    assign ui.o_gains       = gains_q;
    assign ui.o_offset      = offset_q;
    assign ui.o_play_enable = play_q;
    assign ui.o_eq_reset    = eq_reset_q;

endmodule
